// File: rtl/dlf_iir_mc.sv
// Multi-channel, time-multiplexed 3rd-order IIR loop filter.
// One shared multiplier walks seven terms per sample out of a per-channel
// history store, then the result is rounded, saturated and fed back.
module dlf_iir_mc #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 20,
  parameter int COEF_FRAC = 18,
  parameter int NUM_CH    = 4,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int ACC_W     = DATA_W + COEF_W + 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [2:0]               coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata
);

  localparam int PROD_W = COEF_W + DATA_W;
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state, state_nx;

  logic [2:0]                k;
  logic signed [COEF_W-1:0]  coef [7];
  logic signed [DATA_W-1:0]  x_hist [NUM_CH][3];
  logic signed [DATA_W-1:0]  y_hist [NUM_CH][3];

  logic [CH_W-1:0]           cur_ch;
  logic signed [DATA_W-1:0]  cur_x;
  logic [1:0]                cur_mode;
  logic signed [ACC_W-1:0]   acc;

  logic                      ch_ok;
  logic signed [COEF_W-1:0]  coef_sel;
  logic signed [DATA_W-1:0]  data_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [ACC_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  filt_data;
  logic                      filt_sat;
  logic signed [DATA_W-1:0]  res_data;
  logic                      res_sat;
  logic                      res_upd;
  logic                      accept;

  // A channel index is only out of range when NUM_CH is not a power of two.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full_ch
      assign ch_ok = 1'b1;
    end else begin : g_part_ch
      assign ch_ok = (32'(cur_ch) < 32'(NUM_CH));
    end
  endgenerate

  assign accept = in_valid && in_ready;

  // State register; reset aborts any computation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake; a coefficient write blocks sample acceptance.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !coef_we;
        if (in_valid && !coef_we) state_nx = MAC;
      end
      MAC:     if (k == 3'd6) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand mux for term k: b0..b3 pair with x, x1..x3; a1..a3 with y1..y3.
  always_comb begin
    coef_sel = '0;
    data_sel = '0;
    case (k)
      3'd0: begin coef_sel = coef[0]; data_sel = cur_x;            end
      3'd1: begin coef_sel = coef[1]; data_sel = x_hist[cur_ch][0]; end
      3'd2: begin coef_sel = coef[2]; data_sel = x_hist[cur_ch][1]; end
      3'd3: begin coef_sel = coef[3]; data_sel = x_hist[cur_ch][2]; end
      3'd4: begin coef_sel = coef[4]; data_sel = y_hist[cur_ch][0]; end
      3'd5: begin coef_sel = coef[5]; data_sel = y_hist[cur_ch][1]; end
      3'd6: begin coef_sel = coef[6]; data_sel = y_hist[cur_ch][2]; end
      default: begin coef_sel = '0; data_sel = '0; end
    endcase
  end

  assign prod     = coef_sel * data_sel;
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  // Round half toward +inf, drop the fraction, then clip to the sample range.
  always_comb begin
    rounded   = acc + RND_HALF;
    shifted   = rounded >>> COEF_FRAC;
    filt_sat  = 1'b0;
    filt_data = shifted[DATA_W-1:0];
    if (shifted > SAT_HI) begin
      filt_data = SAT_HI[DATA_W-1:0];
      filt_sat  = 1'b1;
    end else if (shifted < SAT_LO) begin
      filt_data = SAT_LO[DATA_W-1:0];
      filt_sat  = 1'b1;
    end
  end

  // Pick the result by mode; hold and invalid channels leave histories alone.
  always_comb begin
    res_data = '0;
    res_sat  = 1'b0;
    res_upd  = 1'b0;
    if (ch_ok) begin
      case (cur_mode)
        2'b01: begin res_data = cur_x;             res_upd = 1'b1; end
        2'b10: begin res_data = y_hist[cur_ch][0];                 end
        default: begin
          res_data = filt_data;
          res_sat  = filt_sat;
          res_upd  = 1'b1;
        end
      endcase
    end
  end

  // Datapath: coefficient writes, sample latch, MAC sequencing, output and history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) coef[i] <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int j = 0; j < 3; j++) begin
          x_hist[c][j] <= '0;
          y_hist[c][j] <= '0;
        end
      end
      k         <= '0;
      cur_ch    <= '0;
      cur_x     <= '0;
      cur_mode  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we) begin
            for (int i = 0; i < 7; i++) begin
              if (coef_addr == 3'(i)) coef[i] <= coef_wdata;
            end
          end
          if (accept) begin
            cur_ch   <= in_ch;
            cur_x    <= in_data;
            cur_mode <= mode;
            acc      <= '0;
            k        <= '0;
          end
        end
        MAC: begin
          if (k >= 3'd4) acc <= acc - prod_ext;
          else           acc <= acc + prod_ext;
          k <= k + 3'd1;
        end
        OUT: begin
          out_valid <= 1'b1;
          out_data  <= res_data;
          out_ch    <= cur_ch;
          out_sat   <= res_sat;
          if (res_upd) begin
            x_hist[cur_ch][2] <= x_hist[cur_ch][1];
            x_hist[cur_ch][1] <= x_hist[cur_ch][0];
            x_hist[cur_ch][0] <= cur_x;
            y_hist[cur_ch][2] <= y_hist[cur_ch][1];
            y_hist[cur_ch][1] <= y_hist[cur_ch][0];
            y_hist[cur_ch][0] <= res_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dlf_iir_mc.sv
// Directed bench for dlf_iir_mc: a per-channel arithmetic model predicts every
// result, a negedge compare process checks out_valid on every cycle, and
// literal expectations pin the model on the hand-worked cases.
module tb_dlf_iir_mc;

  localparam int DATA_W = 8;
  localparam int COEF_W = 20;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH_W-1:0]   in_ch = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic [1:0]        mode = '0;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic              coef_we = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic [COEF_W-1:0] coef_wdata = '0;

  dlf_iir_mc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data), .mode(mode),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: coefficients and histories as plain integers.
  int coef_m [7];
  int xh [NUM_CH][3];
  int yh [NUM_CH][3];
  int last_y;
  bit last_sat;

  typedef struct { int due; int ch; int data; bit sat; } exp_t;
  exp_t exp_q [$];

  task automatic modelReset();
    for (int i = 0; i < 7; i++) coef_m[i] = 0;
    for (int c = 0; c < NUM_CH; c++)
      for (int j = 0; j < 3; j++) begin xh[c][j] = 0; yh[c][j] = 0; end
  endtask

  // y = sum(b*x) - sum(a*y), rounded half up at 2^-18, clipped to 8 bits.
  task automatic modelStep(input int ch, input int x, input int md);
    longint acc;
    bit upd;
    last_sat = 1'b0;
    upd = 1'b1;
    if (md == 1) begin
      last_y = x;
    end else if (md == 2) begin
      last_y = yh[ch][0];
      upd = 1'b0;
    end else begin
      acc = longint'(coef_m[0]) * x + longint'(coef_m[1]) * xh[ch][0]
          + longint'(coef_m[2]) * xh[ch][1] + longint'(coef_m[3]) * xh[ch][2]
          - longint'(coef_m[4]) * yh[ch][0] - longint'(coef_m[5]) * yh[ch][1]
          - longint'(coef_m[6]) * yh[ch][2];
      acc = (acc + 64'sd131072) >>> 18;
      if (acc > 127)       begin last_y = 127;  last_sat = 1'b1; end
      else if (acc < -128) begin last_y = -128; last_sat = 1'b1; end
      else                 last_y = int'(acc);
    end
    if (upd) begin
      xh[ch][2] = xh[ch][1]; xh[ch][1] = xh[ch][0]; xh[ch][0] = x;
      yh[ch][2] = yh[ch][1]; yh[ch][1] = yh[ch][0]; yh[ch][0] = last_y;
    end
  endtask

  // Every cycle out of reset: a strobe is either due with known data or absent.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (out_valid !== 1'b1 || int'($signed(out_data)) != exp_q[0].data ||
            int'(out_ch) != exp_q[0].ch || out_sat !== exp_q[0].sat) begin
          errors++;
          $display("[TB] FAIL result: got valid=%b ch=%0d data=%0d sat=%b, expected valid=1 ch=%0d data=%0d sat=%b",
                   out_valid, out_ch, $signed(out_data), out_sat, exp_q[0].ch, exp_q[0].data, exp_q[0].sat);
        end
        void'(exp_q.pop_front());
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stray_valid: got out_valid=%b at cycle %0d, expected 0", out_valid, cyc);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Offer one sample, optionally try a coefficient write mid-MAC, and end in IDLE
  // on the cycle the result is strobed.
  task automatic applyStimulus(input int ch, input int x, input int md,
                               input bit mid_we, input logic [2:0] mid_addr,
                               input logic [COEF_W-1:0] mid_data);
    bit busy_bad;
    int w;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_ch = CH_W'(ch); in_data = DATA_W'(x); mode = 2'(md);
    #1;
    w = 0;
    while (!in_ready && w < 30) begin @(negedge clk); #1; w++; end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    modelStep(ch, x, md);
    e.due = cyc + 9; e.ch = ch; e.data = last_y; e.sat = last_sat;
    exp_q.push_back(e);
    busy_bad = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
      if (n == 3) coef_we = 1'b0;
      #1;
      if (in_ready !== 1'b0) busy_bad = 1'b1;
      if (mid_we && n == 2) begin coef_we = 1'b1; coef_addr = mid_addr; coef_wdata = mid_data; end
    end
    check("in_ready_busy", int'(busy_bad), 0);
    @(negedge clk);
  endtask

  task automatic send(input int ch, input int x, input int md);
    applyStimulus(ch, x, md, 1'b0, 3'd0, '0);
  endtask

  task automatic writeCoef(input logic [2:0] addr, input logic [COEF_W-1:0] val);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = addr; coef_wdata = val;
    @(negedge clk);
    coef_we = 1'b0;
    if (addr != 3'd7) coef_m[addr] = int'($signed(val));
  endtask

  // Held result must match both the hand-worked literal and the model.
  task automatic checkOutput(input string name, input int want, input bit want_sat);
    checks++;
    if (int'($signed(out_data)) != want || out_sat !== want_sat || last_y != want) begin
      errors++;
      $display("[TB] FAIL %s: got data=%0d sat=%b model=%0d expected data=%0d sat=%b",
               name, $signed(out_data), out_sat, last_y, want, want_sat);
    end
  endtask

  int imp [9] = '{64, 32, 16, 8, 4, 2, 1, 1, 1};
  int passv [4] = '{10, -20, 127, -128};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_ch", int'(out_ch), 0);
    check("reset_out_sat", int'(out_sat), 0);
    check("reset_in_ready", int'(in_ready), 1);

    $display("[TB] zero coefficients");
    send(0, 50, 0);
    checkOutput("zero_coef", 0, 1'b0);

    $display("[TB] unity gain passthrough");
    writeCoef(3'd0, 20'h40000);
    applyStimulus(0, passv[0], 0, 1'b1, 3'd0, 20'h00000);
    checkOutput("unity_0", passv[0], 1'b0);
    for (int i = 1; i < 4; i++) begin
      send(0, passv[i], 0);
      checkOutput("unity", passv[i], 1'b0);
    end

    $display("[TB] saturation and rounding");
    writeCoef(3'd0, 20'h60000);
    send(0, 100, 0);
    checkOutput("sat_pos", 127, 1'b1);
    send(0, -100, 0);
    checkOutput("sat_neg", -128, 1'b1);
    writeCoef(3'd0, 20'h20000);
    send(0, 3, 0);
    checkOutput("round_pos", 2, 1'b0);
    send(0, -3, 0);
    checkOutput("round_neg", -1, 1'b0);

    $display("[TB] feedback limit cycle with interleaved channel");
    writeCoef(3'd0, 20'h40000);
    writeCoef(3'd4, 20'hE0000);
    writeCoef(3'd7, 20'h12345);
    for (int i = 0; i < 9; i++) begin
      send(0, (i == 0) ? 64 : 0, 0);
      checkOutput("impulse", imp[i], 1'b0);
      send(1, 0, 0);
      checkOutput("isolation", 0, 1'b0);
    end

    $display("[TB] mode sequence and write collision");
    writeCoef(3'd4, 20'h00000);
    send(2, 20, 0);  checkOutput("mode_filter", 20, 1'b0);
    send(2, 99, 2);  checkOutput("mode_hold", 20, 1'b0);
    send(2, -7, 1);  checkOutput("mode_bypass", -7, 1'b0);
    send(2, 0, 3);   checkOutput("mode_filter11", 0, 1'b0);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 20'h20000;
    in_valid = 1'b1; in_ch = 2'd2; in_data = 8'd40; mode = 2'b00;
    #1;
    check("collision_ready", int'(in_ready), 0);
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0;
    coef_m[0] = 32'h20000;
    send(2, 40, 0);  checkOutput("after_collision", 20, 1'b0);

    $display("[TB] full third-order response on ch3");
    writeCoef(3'd0, 20'h40000);
    writeCoef(3'd1, 20'h20000);
    writeCoef(3'd2, 20'h10000);
    writeCoef(3'd3, 20'h08000);
    writeCoef(3'd5, 20'h10000);
    writeCoef(3'd6, 20'hF0000);
    send(3, 40, 0);  checkOutput("ord3_0", 40, 1'b0);
    send(3, -8, 0);  checkOutput("ord3_1", 12, 1'b0);
    send(3, 16, 0);  checkOutput("ord3_2", 12, 1'b0);
    send(3, 0, 0);   checkOutput("ord3_3", 18, 1'b0);
    send(3, 0, 0);
    send(3, 100, 0);

    $display("[TB] reset during MAC");
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd3; in_data = 8'd60; mode = 2'b00;
    #1;
    check("pre_reset_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_ready", int'(in_ready), 1);
    check("post_reset_valid", int'(out_valid), 0);
    check("post_reset_data", int'(out_data), 0);
    send(3, 77, 2);  checkOutput("post_reset_hold", 0, 1'b0);
    send(0, 50, 0);  checkOutput("post_reset_zero", 0, 1'b0);

    repeat (12) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
